bp_update_unit: RTL and testbench

Parametrised gshare training unit that sits between the AGEX stage and the branch predictor's PHT/BTB write ports. It accepts one resolved control-flow record per cycle, computes the saturating PHT counter update, the BTB entry and the new global history, and detects mispredictions. Update records are queued in an internal FIFO so predictor write-port stalls do not stall AGEX until the FIFO fills. It also keeps an architectural BHR, issues a registered history/PC recovery pulse on mispredict, and maintains branch and mispredict performance counters.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/bp_update_unit_if.sv | 48 ++++
 rtl/bp_update_fifo.sv | 49 ++++
 rtl/bp_update_unit.sv | 86 ++++++++
 tb/tb_bp_update_unit.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared widths, the queued update record and the PHT counter helper
package bp_pkg;
    localparam int BP_DBITS        = 32;
    localparam int BP_GHR_BITS     = 8;
    localparam int BP_CTR_BITS     = 2;
    localparam int BP_BTB_IDX_BITS = 4;
    localparam int BP_FIFO_DEPTH   = 4;
    localparam int BP_CNT_BITS     = 32;
    localparam int BP_TAG_BITS     = BP_DBITS - BP_BTB_IDX_BITS - 2;

    typedef struct packed {
        logic [BP_GHR_BITS-1:0]     pht_idx;
        logic [BP_CTR_BITS-1:0]     pht_ctr;
        logic                       btb_we;
        logic [BP_BTB_IDX_BITS-1:0] btb_idx;
        logic [BP_TAG_BITS-1:0]     btb_tag;
        logic [BP_DBITS-1:0]        btb_target;
    } bp_upd_t;

    function automatic logic [BP_CTR_BITS-1:0] sat_ctr(input logic [BP_CTR_BITS-1:0] c, input logic up);
        return up ? (&c ? c : c + BP_CTR_BITS'(1)) : (|c ? c - BP_CTR_BITS'(1) : c);
    endfunction
endpackage

// File: rtl/bp_update_unit_if.sv
// bp_update_unit_if: AGEX record input, predictor update output and status bundle
interface bp_update_unit_if #(
    parameter int DBITS        = 32,
    parameter int GHR_BITS     = 8,
    parameter int CTR_BITS     = 2,
    parameter int BTB_IDX_BITS = 4,
    parameter int CNT_BITS     = 32
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DBITS-1:0]              in_pc;
    logic                          in_is_branch;
    logic                          in_taken;
    logic [DBITS-1:0]              in_target;
    logic [GHR_BITS-1:0]           in_bhr;
    logic [CTR_BITS-1:0]           in_ctr;
    logic                          in_pred_taken;
    logic [DBITS-1:0]              in_pred_target;
    logic                          upd_valid;
    logic                          upd_ready;
    logic [GHR_BITS-1:0]           upd_pht_idx;
    logic [CTR_BITS-1:0]           upd_pht_ctr;
    logic                          upd_btb_we;
    logic [BTB_IDX_BITS-1:0]       upd_btb_idx;
    logic [DBITS-BTB_IDX_BITS-3:0] upd_btb_tag;
    logic [DBITS-1:0]              upd_btb_target;
    logic [GHR_BITS-1:0]           arch_bhr;
    logic                          recover_valid;
    logic [GHR_BITS-1:0]           recover_bhr;
    logic [DBITS-1:0]              recover_pc;
    logic [CNT_BITS-1:0]           br_count;
    logic [CNT_BITS-1:0]           mispred_count;

    modport master (
        output in_valid, in_pc, in_is_branch, in_taken, in_target, in_bhr, in_ctr,
               in_pred_taken, in_pred_target, upd_ready,
        input  in_ready, upd_valid, upd_pht_idx, upd_pht_ctr, upd_btb_we, upd_btb_idx,
               upd_btb_tag, upd_btb_target, arch_bhr, recover_valid, recover_bhr,
               recover_pc, br_count, mispred_count
    );
    modport slave (
        input  in_valid, in_pc, in_is_branch, in_taken, in_target, in_bhr, in_ctr,
               in_pred_taken, in_pred_target, upd_ready,
        output in_ready, upd_valid, upd_pht_idx, upd_pht_ctr, upd_btb_we, upd_btb_idx,
               upd_btb_tag, upd_btb_target, arch_bhr, recover_valid, recover_bhr,
               recover_pc, br_count, mispred_count
    );
endinterface

// File: rtl/bp_update_fifo.sv
// bp_update_fifo: synchronous valid/ready queue of update records, no bypass
module bp_update_fifo #(
    parameter int  DEPTH = 4,
    parameter type rec_t = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  rec_t din_i,
    input  logic pop_i,
    output rec_t dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = $clog2(DEPTH);

    rec_t          mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (PW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign dout_o  = mem_q[rd_q];

    always_comb begin
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wr_d    = do_push ? wr_q + PW'(1) : wr_q;
        rd_d    = do_pop ? rd_q + PW'(1) : rd_q;
        cnt_d   = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end
endmodule

// File: rtl/bp_update_unit.sv
// bp_update_unit: gshare training, history/recovery tracking and branch statistics
module bp_update_unit
    import bp_pkg::*;
#(
    parameter int DBITS        = BP_DBITS,
    parameter int GHR_BITS     = BP_GHR_BITS,
    parameter int CTR_BITS     = BP_CTR_BITS,
    parameter int BTB_IDX_BITS = BP_BTB_IDX_BITS,
    parameter int FIFO_DEPTH   = BP_FIFO_DEPTH,
    parameter int CNT_BITS     = BP_CNT_BITS
) (
    input logic clk,
    input logic reset,
    bp_update_unit_if.slave bus
);
    bp_upd_t             rec, head;
    logic                full, empty, br, mispred;
    logic [GHR_BITS-1:0] new_bhr;
    logic [GHR_BITS-1:0] arch_bhr_q, arch_bhr_d, rbhr_q, rbhr_d;
    logic [CNT_BITS-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
    logic                rv_q, rv_d;
    logic [DBITS-1:0]    rpc_q, rpc_d;

    bp_update_fifo #(.DEPTH(FIFO_DEPTH), .rec_t(bp_upd_t)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (br),
        .din_i   (rec),
        .pop_i   (bus.upd_ready),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.in_ready       = !full;
    assign bus.upd_valid      = !empty;
    assign bus.upd_pht_idx    = head.pht_idx;
    assign bus.upd_pht_ctr    = head.pht_ctr;
    assign bus.upd_btb_we     = head.btb_we;
    assign bus.upd_btb_idx    = head.btb_idx;
    assign bus.upd_btb_tag    = head.btb_tag;
    assign bus.upd_btb_target = head.btb_target;
    assign bus.arch_bhr       = arch_bhr_q;
    assign bus.recover_valid  = rv_q;
    assign bus.recover_bhr    = rbhr_q;
    assign bus.recover_pc     = rpc_q;
    assign bus.br_count       = br_cnt_q;
    assign bus.mispred_count  = mis_cnt_q;

    always_comb begin
        br             = bus.in_valid && !full && bus.in_is_branch;
        new_bhr        = {bus.in_bhr[GHR_BITS-2:0], bus.in_taken};
        mispred        = (bus.in_taken != bus.in_pred_taken) ||
                         (bus.in_taken && bus.in_target != bus.in_pred_target);
        rec.pht_idx    = bus.in_pc[GHR_BITS+1:2] ^ bus.in_bhr;
        rec.pht_ctr    = sat_ctr(bus.in_ctr, bus.in_taken);
        rec.btb_we     = bus.in_taken;
        rec.btb_idx    = bus.in_pc[BTB_IDX_BITS+1:2];
        rec.btb_tag    = bus.in_pc[DBITS-1:BTB_IDX_BITS+2];
        rec.btb_target = bus.in_target;
        arch_bhr_d     = br ? new_bhr : arch_bhr_q;
        br_cnt_d       = (br && !(&br_cnt_q)) ? br_cnt_q + CNT_BITS'(1) : br_cnt_q;
        mis_cnt_d      = (br && mispred && !(&mis_cnt_q)) ? mis_cnt_q + CNT_BITS'(1) : mis_cnt_q;
        rv_d           = br && mispred;
        rbhr_d         = rv_d ? new_bhr : rbhr_q;
        rpc_d          = rv_d ? (bus.in_taken ? bus.in_target : bus.in_pc + DBITS'(4)) : rpc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            arch_bhr_q <= '0;
            br_cnt_q   <= '0;
            mis_cnt_q  <= '0;
            rv_q       <= 1'b0;
            rbhr_q     <= '0;
            rpc_q      <= '0;
        end else begin
            arch_bhr_q <= arch_bhr_d;
            br_cnt_q   <= br_cnt_d;
            mis_cnt_q  <= mis_cnt_d;
            rv_q       <= rv_d;
            rbhr_q     <= rbhr_d;
            rpc_q      <= rpc_d;
        end
    end
endmodule

// File: tb/tb_bp_update_unit.sv
// tb_bp_update_unit: directed table, queue/full/reset sequences and random traffic vs a queue model
module tb_bp_update_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bp_update_unit_if bus();
    bp_update_unit dut (.clk(clk), .reset(reset), .bus(bus.slave));

    typedef struct {
        logic [31:0] pc; logic [7:0] bhr; logic [1:0] ctr; logic tk; logic [31:0] tgt;
        logic ptk; logic [31:0] ptgt;
        logic [7:0] e_idx; logic [1:0] e_ctr; logic e_we; logic [3:0] e_bidx; logic [25:0] e_tag;
        logic [7:0] e_bhr; logic e_rv; logic [31:0] e_rpc;
    } vec_t;

    typedef struct {
        logic [7:0] idx; logic [1:0] ctr; logic we; logic [3:0] bidx; logic [25:0] tag; logic [31:0] tgt;
    } m_rec_t;

    int checks = 0;
    int errors = 0;
    m_rec_t mq[$];
    logic [7:0]  m_bhr = 0, m_rbhr = 0;
    logic [31:0] m_br = 0, m_mis = 0, m_rpc = 0;
    logic        m_rv = 0;
    vec_t        vecs[6];

    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic drive(logic [31:0] pc, logic [7:0] bh, logic [1:0] c, logic tk, logic [31:0] tg, logic pt, logic [31:0] ptg);
        bus.in_valid = 1; bus.in_is_branch = 1; bus.in_pc = pc; bus.in_bhr = bh; bus.in_ctr = c;
        bus.in_taken = tk; bus.in_target = tg; bus.in_pred_taken = pt; bus.in_pred_target = ptg;
    endtask

    // checks current outputs against the model, then advances model and DUT by one edge
    task automatic cycle();
        m_rec_t r;
        int c;
        logic [7:0] nb;
        logic acc, pop, mis;
        chk("in_ready", bus.in_ready, mq.size() < 4);
        chk("upd_valid", bus.upd_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("q_idx", bus.upd_pht_idx, mq[0].idx);
            chk("q_ctr", bus.upd_pht_ctr, mq[0].ctr);
            chk("q_we", bus.upd_btb_we, mq[0].we);
            chk("q_bidx", bus.upd_btb_idx, mq[0].bidx);
            chk("q_tag", bus.upd_btb_tag, mq[0].tag);
            chk("q_tgt", bus.upd_btb_target, mq[0].tgt);
        end
        chk("arch_bhr", bus.arch_bhr, m_bhr);
        chk("br_count", bus.br_count, m_br);
        chk("mispred_count", bus.mispred_count, m_mis);
        chk("recover_valid", bus.recover_valid, m_rv);
        chk("recover_bhr", bus.recover_bhr, m_rbhr);
        chk("recover_pc", bus.recover_pc, m_rpc);
        acc = bus.in_valid && bus.in_is_branch && mq.size() < 4;
        pop = bus.upd_ready && mq.size() != 0;
        c = int'(bus.in_ctr);
        c = bus.in_taken ? (c == 3 ? 3 : c + 1) : (c == 0 ? 0 : c - 1);
        nb = 8'((int'(bus.in_bhr) * 2 + int'(bus.in_taken)) % 256);
        mis = (bus.in_taken != bus.in_pred_taken) || (bus.in_taken && bus.in_target != bus.in_pred_target);
        r.idx = 8'((bus.in_pc / 4) % 256) ^ bus.in_bhr;
        r.ctr = 2'(c);
        r.we = bus.in_taken;
        r.bidx = 4'((bus.in_pc / 4) % 16);
        r.tag = 26'(bus.in_pc / 64);
        r.tgt = bus.in_target;
        if (reset) begin
            mq.delete(); m_bhr = 0; m_br = 0; m_mis = 0; m_rv = 0; m_rbhr = 0; m_rpc = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(r);
                m_bhr = nb;
                if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                if (mis && m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
            end
            m_rv = acc && mis;
            if (m_rv) begin
                m_rbhr = nb;
                m_rpc = bus.in_taken ? bus.in_target : bus.in_pc + 32'd4;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vecs[0] = '{32'h100, 8'h05, 2'd3, 1, 32'h180, 1, 32'h180, 8'h45, 2'd3, 1, 4'h0, 26'h4, 8'h0B, 0, 32'h0};
        vecs[1] = '{32'h200, 8'h0B, 2'd0, 0, 32'h0, 1, 32'h0, 8'h8B, 2'd0, 0, 4'h0, 26'h8, 8'h16, 1, 32'h204};
        vecs[2] = '{32'h104, 8'h16, 2'd1, 1, 32'h340, 1, 32'h300, 8'h57, 2'd2, 1, 4'h1, 26'h4, 8'h2D, 1, 32'h340};
        vecs[3] = '{32'hFFFF_FFFC, 8'hFF, 2'd2, 0, 32'h0, 0, 32'h10, 8'h00, 2'd1, 0, 4'hF, 26'h3FF_FFFF, 8'hFE, 0, 32'h0};
        vecs[4] = '{32'hFFFF_FFFC, 8'h80, 2'd1, 0, 32'h0, 1, 32'h0, 8'h7F, 2'd0, 0, 4'hF, 26'h3FF_FFFF, 8'h00, 1, 32'h0};
        vecs[5] = '{32'h1234_5678, 8'h3C, 2'd2, 1, 32'hDEAD_BEE0, 0, 32'h0, 8'hA2, 2'd3, 1, 4'hE, 26'h48_D159, 8'h79, 1, 32'hDEAD_BEE0};

        bus.in_valid = 0; bus.in_is_branch = 0; bus.in_pc = 0; bus.in_bhr = 0; bus.in_ctr = 0;
        bus.in_taken = 0; bus.in_target = 0; bus.in_pred_taken = 0; bus.in_pred_target = 0; bus.upd_ready = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        cycle();

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].bhr, vecs[i].ctr, vecs[i].tk, vecs[i].tgt, vecs[i].ptk, vecs[i].ptgt);
            cycle();
            chk($sformatf("v%0d_idx", i), bus.upd_pht_idx, vecs[i].e_idx);
            chk($sformatf("v%0d_ctr", i), bus.upd_pht_ctr, vecs[i].e_ctr);
            chk($sformatf("v%0d_we", i), bus.upd_btb_we, vecs[i].e_we);
            chk($sformatf("v%0d_bidx", i), bus.upd_btb_idx, vecs[i].e_bidx);
            chk($sformatf("v%0d_tag", i), bus.upd_btb_tag, vecs[i].e_tag);
            chk($sformatf("v%0d_bhr", i), bus.arch_bhr, vecs[i].e_bhr);
            chk($sformatf("v%0d_rv", i), bus.recover_valid, vecs[i].e_rv);
            if (vecs[i].e_rv) chk($sformatf("v%0d_rpc", i), bus.recover_pc, vecs[i].e_rpc);
        end

        bus.in_is_branch = 0;
        cycle();
        chk("nonbr_upd_valid", bus.upd_valid, 0);
        chk("nonbr_br_count", bus.br_count, 6);
        chk("nonbr_mis_count", bus.mispred_count, 4);
        chk("nonbr_bhr", bus.arch_bhr, 8'h79);

        bus.upd_ready = 0;
        for (int i = 0; i < 5; i++) begin
            drive(32'h1000 + 32'(i * 4), 8'(i), 2'd1, 1, 32'h2000, 1, 32'h2000);
            cycle();
            if (i == 3) chk("full_in_ready", bus.in_ready, 0);
        end
        chk("full_br_count", bus.br_count, 10);
        bus.upd_ready = 1;
        cycle();
        chk("after_pop_ready", bus.in_ready, 1);
        cycle();
        bus.in_valid = 0;
        repeat (5) cycle();
        chk("drain_br_count", bus.br_count, 11);
        chk("drain_empty", bus.upd_valid, 0);

        bus.upd_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h40 + 32'(i * 4), 8'h11, 2'd0, 0, 32'h0, 1, 32'h0);
            cycle();
        end
        reset = 1; bus.upd_ready = 1;
        cycle();
        reset = 0; bus.in_valid = 0;
        chk("rst_upd_valid", bus.upd_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_br_count", bus.br_count, 0);
        chk("rst_mis_count", bus.mispred_count, 0);
        chk("rst_recover", bus.recover_valid, 0);
        cycle();

        for (int n = 0; n < 400; n++) begin
            logic [31:0] tg;
            tg = $urandom;
            reset = ($urandom_range(0, 49) == 0);
            drive($urandom, 8'($urandom), 2'($urandom), 1'($urandom), tg, 1'($urandom),
                  $urandom_range(0, 1) ? tg : $urandom);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.in_is_branch = ($urandom_range(0, 4) != 0);
            bus.upd_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        reset = 0; bus.in_valid = 0; bus.upd_ready = 1;
        repeat (6) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
